// File: rtl/exec_ctrl.sv
// Run/halt/step/breakpoint execution controller for a debug core.
// Buttons are synchronized and debounced; the FSM state decodes directly to stall.
module exec_ctrl #(
  parameter int unsigned DEBOUNCE_CYCLES = 20'd1_000_000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        btn_run,
  input  logic        btn_step,
  input  logic        bp_en,
  input  logic        bp_load,
  input  logic [31:0] bp_addr_in,
  input  logic [31:0] pc,
  input  logic        cnt_clr,
  output logic        stall,
  output logic [1:0]  state,
  output logic        bp_hit,
  output logic [31:0] cycle_count
);

  localparam int unsigned CW = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);

  typedef enum logic [1:0] {
    HALT  = 2'b00,
    RUN   = 2'b01,
    STEP  = 2'b10,
    BREAK = 2'b11
  } state_t;

  state_t state_q, state_d;

  // Index 0 = run button, index 1 = step button.
  logic [1:0]         btn;
  logic [1:0]         sync1, sync2, deb, deb_d, press;
  logic [1:0][CW-1:0] cnt;
  logic               run_p, step_p;

  logic [31:0] bp_reg, pc_prev;
  logic        bp_match;

  assign btn = {btn_step, btn_run};

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      sync1 <= '0;
      sync2 <= '0;
      deb   <= '0;
      deb_d <= '0;
      cnt   <= '0;
    end else begin
      sync1 <= btn;
      sync2 <= sync1;
      deb_d <= deb;
      for (int unsigned i = 0; i < 2; i++) begin
        if (sync2[i] != deb[i]) begin
          if (cnt[i] == CNT_LAST) begin
            deb[i] <= sync2[i];
            cnt[i] <= '0;
          end else begin
            cnt[i] <= cnt[i] + CW'(1);
          end
        end else begin
          cnt[i] <= '0;
        end
      end
    end
  end

  assign press  = deb & ~deb_d;
  assign run_p  = press[0];
  assign step_p = press[1];

  // pc_prev suppresses a re-break when resuming while parked on the breakpoint.
  assign bp_match = bp_en && (pc == bp_reg) && (pc != pc_prev);

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      HALT, BREAK: begin
        if (run_p)       state_d = RUN;
        else if (step_p) state_d = STEP;
      end
      RUN: begin
        if (run_p)         state_d = HALT;
        else if (bp_match) state_d = BREAK;
      end
      STEP:    state_d = HALT;
      default: state_d = HALT;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= HALT;
      bp_reg      <= '0;
      pc_prev     <= '0;
      cycle_count <= '0;
    end else begin
      state_q <= state_d;
      pc_prev <= pc;
      if (bp_load) bp_reg <= bp_addr_in;
      if (cnt_clr)     cycle_count <= '0;
      else if (!stall) cycle_count <= cycle_count + 32'd1;
    end
  end

  assign state  = state_q;
  assign stall  = (state_q == HALT) || (state_q == BREAK);
  assign bp_hit = (state_q == BREAK);

endmodule

// File: tb/tb_exec_ctrl.sv
// Randomized bench for exec_ctrl with a cycle-level behavioural model and
// directed scenarios pinning debounce, stepping, breakpoints and the counter.
module tb_exec_ctrl;

  localparam int unsigned N = 4;

  logic        clk = 1'b0;
  logic        rst;
  logic        btn_run, btn_step, bp_en, bp_load, cnt_clr;
  logic [31:0] bp_addr_in, pc;
  logic        stall, bp_hit;
  logic [1:0]  state;
  logic [31:0] cycle_count;

  int checks = 0;
  int errors = 0;

  exec_ctrl #(.DEBOUNCE_CYCLES(N)) dut (
    .clk         (clk),
    .rst         (rst),
    .btn_run     (btn_run),
    .btn_step    (btn_step),
    .bp_en       (bp_en),
    .bp_load     (bp_load),
    .bp_addr_in  (bp_addr_in),
    .pc          (pc),
    .cnt_clr     (cnt_clr),
    .stall       (stall),
    .state       (state),
    .bp_hit      (bp_hit),
    .cycle_count (cycle_count)
  );

  always #5 clk = ~clk;

  // Behavioural model: index 0 = run button, 1 = step button; state codes 0 HALT, 1 RUN, 2 STEP, 3 BREAK.
  bit [1:0]    m_s1, m_s2, m_deb, m_deb_prev;
  int          m_streak [2];
  bit [1:0]    m_state;
  bit [31:0]   m_count, m_bp, m_pc_prev;

  task automatic model_reset();
    m_s1 = '0; m_s2 = '0; m_deb = '0; m_deb_prev = '0;
    m_streak[0] = 0; m_streak[1] = 0;
    m_state = 2'd0; m_count = '0; m_bp = '0; m_pc_prev = '0;
  endtask

  task automatic model_step();
    bit [1:0] raw;
    bit [1:0] pressed;
    bit       match, frozen;
    raw     = {btn_step, btn_run};
    pressed = m_deb & ~m_deb_prev;
    match   = bp_en && (pc == m_bp) && (pc != m_pc_prev);
    frozen  = (m_state == 2'd0) || (m_state == 2'd3);
    if (cnt_clr)      m_count = 0;
    else if (!frozen) m_count = m_count + 1;
    case (m_state)
      2'd0, 2'd3: m_state = pressed[0] ? 2'd1 : (pressed[1] ? 2'd2 : m_state);
      2'd1:       m_state = pressed[0] ? 2'd0 : (match ? 2'd3 : 2'd1);
      default:    m_state = 2'd0;
    endcase
    if (bp_load) m_bp = bp_addr_in;
    m_pc_prev  = pc;
    m_deb_prev = m_deb;
    for (int i = 0; i < 2; i++) begin
      if (m_s2[i] != m_deb[i]) begin
        m_streak[i]++;
        if (m_streak[i] == N) begin
          m_deb[i]    = m_s2[i];
          m_streak[i] = 0;
        end
      end else begin
        m_streak[i] = 0;
      end
    end
    m_s2 = m_s1;
    m_s1 = raw;
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    if (rst) model_step();
    #2;
  endtask

  task automatic wait_state(input logic [1:0] target, input int budget);
    for (int i = 0; i < budget; i++) begin
      if (state == target) break;
      tick();
    end
  endtask

  always @(negedge clk) begin
    check("model_state", {30'd0, state}, {30'd0, m_state});
    check("model_stall", {31'd0, stall}, {31'd0, (m_state == 2'd0) || (m_state == 2'd3)});
    check("model_bp_hit", {31'd0, bp_hit}, {31'd0, m_state == 2'd3});
    check("model_count", cycle_count, m_count);
  end

  int low_cycles, trans, lat;
  logic [1:0] prev;

  initial begin
    rst = 1'b0; btn_run = 0; btn_step = 0; bp_en = 0; bp_load = 0; cnt_clr = 0;
    bp_addr_in = '0; pc = '0;
    model_reset();
    repeat (3) tick();
    check("reset_state", {30'd0, state}, 32'd0);
    check("reset_stall", {31'd0, stall}, 32'd1);
    check("reset_count", cycle_count, 32'd0);
    check("reset_bp_hit", {31'd0, bp_hit}, 32'd0);
    rst = 1'b1;
    repeat (5) tick();
    check("idle_halt", {30'd0, state}, 32'd0);

    // Single step with a long hold.
    btn_step = 1; low_cycles = 0;
    for (int i = 0; i < 60; i++) begin
      tick();
      if (!stall) low_cycles++;
    end
    check("step_once", low_cycles, 32'd1);
    check("step_count", cycle_count, 32'd1);
    check("step_back_halt", {30'd0, state}, 32'd0);
    btn_step = 0;
    repeat (10) tick();

    // Bouncing run button, then stable high.
    trans = 0; prev = state;
    for (int i = 0; i < 20; i++) begin
      btn_run = ((i / 2) % 2 == 0);
      tick();
      if (state != prev) trans++;
      prev = state;
    end
    check("bounce_quiet", trans, 32'd0);
    btn_run = 1; lat = 0;
    for (int i = 1; i <= 12; i++) begin
      tick();
      if (state != prev) begin
        trans++;
        if (lat == 0) lat = i;
      end
      prev = state;
    end
    check("bounce_one_transition", trans, 32'd1);
    check("bounce_run", {30'd0, state}, 32'd1);
    check("bounce_latency", lat, 32'd7);
    btn_run = 0;
    repeat (10) tick();
    check("release_no_pulse", {30'd0, state}, 32'd1);

    // Breakpoint hit, resume at the same pc, re-break on re-arrival.
    bp_en = 1; bp_load = 1; bp_addr_in = 32'h10; pc = 32'h0C;
    tick();
    bp_load = 0;
    repeat (2) tick();
    pc = 32'h10;
    tick();
    check("bp_state", {30'd0, state}, 32'd3);
    check("bp_stall", {31'd0, stall}, 32'd1);
    check("bp_hit", {31'd0, bp_hit}, 32'd1);
    btn_run = 1;
    wait_state(2'd1, 12);
    repeat (10) tick();
    check("resume_no_rebreak", {30'd0, state}, 32'd1);
    btn_run = 0;
    repeat (10) tick();
    pc = 32'h14; tick();
    pc = 32'h10; tick();
    check("rebreak", {30'd0, state}, 32'd3);

    // Run press and bp_match land on the same edge in RUN.
    btn_run = 1;
    wait_state(2'd1, 12);
    btn_run = 0;
    repeat (10) tick();
    pc = 32'h0C; tick();
    btn_run = 1;
    repeat (6) tick();
    check("prio_still_run", {30'd0, state}, 32'd1);
    pc = 32'h10;
    tick();
    check("prio_run_over_bp", {30'd0, state}, 32'd0);
    check("prio_no_bp_hit", {31'd0, bp_hit}, 32'd0);
    btn_run = 0; pc = 32'h0C;
    repeat (10) tick();

    // Both buttons pressed together in HALT.
    btn_run = 1; btn_step = 1;
    repeat (7) tick();
    check("both_press_run", {30'd0, state}, 32'd1);
    btn_run = 0; btn_step = 0;
    repeat (10) tick();
    check("step_ignored_in_run", {30'd0, state}, 32'd1);

    // Counter clear, count-up, freeze in HALT.
    cnt_clr = 1; tick(); cnt_clr = 0;
    check("clr_zero", cycle_count, 32'd0);
    tick(); check("clr_one", cycle_count, 32'd1);
    tick(); check("clr_two", cycle_count, 32'd2);
    btn_run = 1;
    repeat (7) tick();
    check("halt_after_press", {30'd0, state}, 32'd0);
    repeat (5) tick();
    check("halt_frozen_count", cycle_count, 32'd9);
    btn_run = 0;
    repeat (10) tick();

    // Asynchronous reset in the middle of RUN.
    btn_run = 1;
    wait_state(2'd1, 12);
    btn_run = 0;
    repeat (3) tick();
    rst = 0; model_reset();
    #1;
    check("async_rst_state", {30'd0, state}, 32'd0);
    check("async_rst_stall", {31'd0, stall}, 32'd1);
    check("async_rst_count", cycle_count, 32'd0);
    check("async_rst_bp_hit", {31'd0, bp_hit}, 32'd0);
    repeat (2) tick();
    rst = 1;
    repeat (12) tick();
    check("post_rst_halt", {30'd0, state}, 32'd0);

    // Randomized traffic against the model.
    for (int c = 0; c < 4000; c++) begin
      if ($urandom_range(7) == 0) btn_run = ~btn_run;
      if ($urandom_range(9) == 0) btn_step = ~btn_step;
      if ($urandom_range(49) == 0) bp_en = ~bp_en;
      if ($urandom_range(2) == 0) begin
        case ($urandom_range(2))
          0:       pc = 32'h0C;
          1:       pc = 32'h10;
          default: pc = 32'h14;
        endcase
      end
      bp_load    = ($urandom_range(31) == 0);
      bp_addr_in = $urandom_range(1) ? 32'h10 : 32'h14;
      cnt_clr    = ($urandom_range(63) == 0);
      if ($urandom_range(499) == 0) begin
        rst = 0; model_reset();
        tick();
        rst = 1;
      end
      tick();
    end
    bp_load = 0; cnt_clr = 0;
    tick();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
